// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

  // Double-dabble nibble correction; a 4-bit result is enough because the input never exceeds 9.
  function automatic logic [3:0] add3_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Decimal digits needed to represent 2**width-1.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int d;
    v = (longint'(1) << width) - 1;
    d = 1;
    while (v >= 10) begin
      v = v / 10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Combinational per-digit adjust: a nibble of 5 or more gets +3 before the next shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = add3_adj(nib_i);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one input bit per clock.
// Optional BIN2BCD_CHANGE_DETECT_EN: an input change while idle starts a conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BW = DIGITS * 4;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_size_err
    $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  b2b_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [SW-1:0] sr_adj, sr_shift;
  logic          bin_chg;
  logic          accept;

`ifdef BIN2BCD_CHANGE_DETECT_EN
  logic [WIDTH-1:0] last_bin_q;

  always_ff @(posedge clk) begin
    if (rst)         last_bin_q <= '0;
    else if (accept) last_bin_q <= bin;
  end

  assign bin_chg = (bin != last_bin_q);
`else
  assign bin_chg = 1'b0;
`endif

  // Change detection only counts in IDLE; a DONE->SHIFT restart needs start.
  assign accept = ((state_q == IDLE) && (start || bin_chg)) ||
                  ((state_q == DONE) && start);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (sr_q[WIDTH+4*g +: 4]),
      .nib_o (sr_adj[WIDTH+4*g +: 4])
    );
  end
  assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];
  assign sr_shift          = sr_adj << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    if (accept) begin
      sr_d  = {{BW{1'b0}}, bin};
      cnt_d = CW'(WIDTH);
    end else if (state_q == SHIFT) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) bcd_d = sr_shift[SW-1 -: BW];
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values against a decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy, done;
  logic [11:0] bcd;

  logic        start16;
  logic [15:0] bin16;
  logic        busy16, done16;
  logic [19:0] bcd16;

  int n_err = 0;
  int n_chk = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain decimal digit extraction.
  function automatic logic [31:0] to_bcd(input int unsigned v, input int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One start pulse, then check busy length, start-to-done latency and the result.
  task automatic run_conv(input int unsigned v, input string tag);
    int lat, nbusy, d0;
    @(posedge clk); #1;
    bin = v[7:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    lat = 999; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
      if (busy) nbusy++;
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy"}, nbusy, 8);
    chk({tag, "_bcd"}, bcd, to_bcd(v, 3));
    @(negedge clk);
    chk({tag, "_done1"}, done, 1'b0);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
  endtask

  initial begin
    int lat, d0;
    int unsigned v;
    rst = 1'b1; start = 1'b0; bin = '0; start16 = 1'b0; bin16 = '0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bcd", bcd, 12'h000);

    // 255 and hold
    run_conv(255, "t1");
    chk("t1_val", bcd, 12'h255);
    d0 = done_cnt;
    cycles(10);
    chk("t1_hold", bcd, 12'h255);
    chk("t1_nodone", done_cnt - d0, 0);

    run_conv(0, "t2a");
    run_conv(9, "t2b");
    run_conv(10, "t2c");
    chk("t2_val", bcd, 12'h010);

    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 255);
      run_conv(v, "rnd");
    end

    // start during SHIFT is ignored
    @(posedge clk); #1;
    bin = 8'd200; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    cycles(2);
    bin = 8'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = 8'd200;
    cycles(25);
    chk("t3_bcd", bcd, 12'h200);
    chk("t3_ndone", done_cnt - d0, 1);

    // reset in the 4th busy cycle
    @(posedge clk); #1;
    bin = 8'd123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    rst = 1'b1; bin = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    chk("t4_bcd", bcd, 12'h000);
    cycles(15);
    chk("t4_ndone", done_cnt - d0, 0);
    chk("t4_bcd2", bcd, 12'h000);
    run_conv(77, "t4b");
    chk("t4_val", bcd, 12'h077);

    // start held high: back-to-back conversions every 9 cycles
    @(posedge clk); #1;
    bin = 8'd45; start = 1'b1;
    lat = 999;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
    end
    chk("t5_first", lat, 10);
    for (int p = 0; p < 3; p++) begin
      lat = 999;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (done) begin lat = c; break; end
      end
      chk("t5_period", lat, 9);
      chk("t5_bcd", bcd, 12'h045);
    end
    start = 1'b0;
    cycles(3);
    chk("t5_idle", busy, 1'b0);

    // 16-bit instance: 65535 and a random value
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 65535 : $urandom_range(0, 65535);
      @(posedge clk); #1;
      bin16 = v[15:0]; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = 999;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (done16) begin lat = c; break; end
      end
      chk("w16_lat", lat, 17);
      chk("w16_bcd", bcd16, to_bcd(v, 5));
    end

    // input change with start low
    run_conv(0, "t6a");
    d0 = done_cnt;
    @(posedge clk); #1;
    bin = 8'd42;
    lat = 999;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin lat = c; break; end
    end
`ifdef BIN2BCD_CHANGE_DETECT_EN
    chk("t6_lat", lat, 10);
    chk("t6_bcd", bcd, 12'h042);
    cycles(20);
    chk("t6_ndone", done_cnt - d0, 1);
`else
    chk("t6_lat", lat, 999);
    chk("t6_bcd", bcd, 12'h000);
    chk("t6_ndone", done_cnt - d0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
